// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg
//   Shared widths, types and the fixed coefficient table for the 16-tap
//   beamformer low-pass FIR. Imported by fir_filter and fir_adder_tree.
//   The table is symmetric, which gives linear phase. Its DC gain is 246.
package fir_filter_pkg;

  localparam int NUM_TAPS = 16;
  localparam int DIN_W    = 32;
  localparam int COEF_W   = 32;
  localparam int PROD_W   = 64;
  localparam int DOUT_W   = 96;

  typedef logic signed [DIN_W-1:0]  sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [DOUT_W-1:0] acc_t;

  localparam coef_t COEFFS [NUM_TAPS] = '{
    32'sd1,  32'sd3,  32'sd7,  32'sd12, 32'sd18, 32'sd24, 32'sd28, 32'sd30,
    32'sd30, 32'sd28, 32'sd24, 32'sd18, 32'sd12, 32'sd7,  32'sd3,  32'sd1
  };

  // Full-precision signed 32x32 product. Both operands are sign-extended
  // to 64 bits first, so the truncated 64-bit result is exact.
  function automatic prod_t tap_mul(input sample_t x, input coef_t c);
    return prod_t'(x) * prod_t'(c);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree
//   Combinational balanced sum of N signed products into one signed
//   OUT_W-bit result. Each product is sign-extended to OUT_W at the leaves,
//   so no level can overflow. The leaf count is rounded up to a power of
//   two, and the padding leaves are zero.
// Ports:
//   prod_in  in   N x IN_W  packed signed products, element 0 = tap 0
//   sum_out  out  OUT_W     signed sum of all products
module fir_adder_tree
  import fir_filter_pkg::*;
#(
  parameter int N     = NUM_TAPS,
  parameter int IN_W  = PROD_W,
  parameter int OUT_W = DOUT_W
) (
  input  logic [N-1:0][IN_W-1:0] prod_in,
  output logic [OUT_W-1:0]       sum_out
);

  localparam int LVLS   = (N > 1) ? $clog2(N) : 1;
  localparam int LEAVES = 1 << LVLS;

  // Heap layout: node 0 is the root, and the children of node j are
  // 2j+1 and 2j+2. The leaves occupy LEAVES-1 .. 2*LEAVES-2.
  logic signed [OUT_W-1:0] node [2*LEAVES-1];

  always_comb begin
    for (int j = 0; j < LEAVES; j++) begin
      if (j < N) node[LEAVES-1+j] = OUT_W'($signed(prod_in[j]));
      else       node[LEAVES-1+j] = '0;
    end
    // Walk the internal nodes from the bottom up, so both children are final.
    for (int j = LEAVES-2; j >= 0; j--) begin
      node[j] = node[2*j+1] + node[2*j+2];
    end
    sum_out = node[0];
  end

endmodule

// File: rtl/fir_filter.sv
// fir_filter
//   Fixed-coefficient, direct-form, 16-tap FIR low-pass filter. The filter
//   takes one signed sample per clock and produces one full-precision signed
//   result per clock. It never stalls.
//   Pipeline: delay line x -> product regs p -> adder tree -> data_out reg.
//   A sample captured at edge k reaches data_out, weighted by COEFFS[0],
//   after edge k+2.
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous active-high reset, clears all state
//   data_in   in   DIN_W   signed sample, captured every edge
//   data_out  out  DOUT_W  signed filtered result, registered
module fir_filter
  import fir_filter_pkg::*;
#(
  parameter int NUM_TAPS = fir_filter_pkg::NUM_TAPS,
  parameter int DIN_W    = fir_filter_pkg::DIN_W,
  parameter int COEF_W   = fir_filter_pkg::COEF_W,
  parameter int DOUT_W   = fir_filter_pkg::DOUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  data_in,
  output logic [DOUT_W-1:0] data_out
);

  // These overrides exist only to document the interface. The coefficient
  // table and tap_mul are sized by the package, so any override must keep
  // the package values.
  localparam int P_W = DIN_W + COEF_W;

  logic [NUM_TAPS-1:0][DIN_W-1:0] x_q, x_d;
  logic [NUM_TAPS-1:0][P_W-1:0]   p_q, p_d;
  logic [DOUT_W-1:0]              dout_q, dout_d;
  logic [DOUT_W-1:0]              tree_sum;

  // Delay line and multiply stage.
  always_comb begin
    x_d    = x_q;
    p_d    = p_q;
    x_d[0] = data_in;
    for (int i = 1; i < NUM_TAPS; i++) begin
      x_d[i] = x_q[i-1];
    end
    for (int i = 0; i < NUM_TAPS; i++) begin
      p_d[i] = tap_mul(sample_t'(x_q[i]), COEFFS[i]);
    end
  end

  fir_adder_tree #(
    .N     (NUM_TAPS),
    .IN_W  (P_W),
    .OUT_W (DOUT_W)
  ) u_tree (
    .prod_in (p_q),
    .sum_out (tree_sum)
  );

  always_comb begin
    dout_d = tree_sum;
  end

  // Reset takes priority over capture and discards the whole history.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      p_q    <= '0;
      dout_q <= '0;
    end else begin
      x_q    <= x_d;
      p_q    <= p_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter
//   Randomized and directed bench for fir_filter. The bench keeps a log of
//   every edge's (rst, data_in). The expected output is recomputed from that
//   log as a plain convolution with the coefficient list. Any reset edge
//   makes that edge and all older history count as zero. The first two
//   edges after a reset also read as zero, because the clears are still
//   draining out of the pipeline.
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [95:0] data_out;

  always #5 clk = ~clk;

  fir_filter dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  int C [16] = '{1, 3, 7, 12, 18, 24, 28, 30, 30, 28, 24, 18, 12, 7, 3, 1};

  typedef struct {
    bit r;
    int v;
  } ev_t;

  ev_t hist[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic signed [95:0] got,
                     input logic signed [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected data_out right after the most recent logged edge.
  function automatic logic signed [95:0] model();
    int m;
    int e;
    logic signed [95:0] acc;
    logic signed [95:0] a;
    m   = hist.size() - 1;
    acc = '0;
    if (hist[m].r) return '0;
    if (m >= 1 && hist[m-1].r) return '0;
    for (int i = 0; i < 16; i++) begin
      e = m - 2 - i;
      if (e < 0) break;
      if (hist[e].r) break;
      a   = hist[e].v;
      acc = acc + a * C[i];
    end
    return acc;
  endfunction

  // One clock: drive inputs, take the edge, then sample 1 time unit later
  // and compare against the model.
  task automatic tick(input bit r, input logic [31:0] d, input string tag = "model");
    ev_t ev;
    rst     = r;
    data_in = d;
    @(posedge clk);
    #1;
    ev.r = r;
    ev.v = int'(d);
    hist.push_back(ev);
    chk(tag, data_out, model());
  endtask

  initial begin
    bit          r;
    logic [31:0] d;
    real         s;
    int          v;

    rst     = 1'b1;
    data_in = '0;

    // Reset held with a nonzero input: the output stays 0 during reset
    // and on the first edge after release.
    repeat (5) begin
      tick(1'b1, 32'd12345, "rst_model");
      chk("rst_hold", data_out, 0);
    end
    tick(1'b0, 32'd0, "rel_model");
    chk("rst_release", data_out, 0);
    repeat (16) tick(1'b0, 32'd0);

    // Impulse: the output walks through the coefficient list, then returns to 0.
    tick(1'b0, 32'd1);
    for (int j = 0; j < 18; j++) begin
      tick(1'b0, 32'd0);
      chk("impulse", data_out, (j >= 1 && j <= 16) ? C[j-1] : 0);
    end

    // Step of 2048: the output settles at 2048 * 246 from edge k+17.
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, 32'd2048);
      if (t >= 17) chk("step", data_out, 503808);
    end

    // One-cycle reset mid-step: the step restarts from 2048 at latency 2.
    tick(1'b1, 32'd2048);
    chk("mid_rst", data_out, 0);
    tick(1'b0, 32'd2048);
    chk("mid_rst_p1", data_out, 0);
    tick(1'b0, 32'd2048);
    chk("mid_rst_p2", data_out, 0);
    tick(1'b0, 32'd2048);
    chk("restart", data_out, 2048);
    repeat (20) tick(1'b0, 32'd2048);
    chk("restart_settle", data_out, 503808);

    // Negative full scale.
    repeat (20) tick(1'b0, 32'h8000_0000);
    chk("neg_fs", data_out, -96'sd528280977408);
    chk("neg_fs_hi", data_out[95:64], 32'hFFFF_FFFF);

    // Random samples, including extremes, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0:       d = 32'h8000_0000;
        1:       d = 32'h7FFF_FFFF;
        default: d = $urandom;
      endcase
      tick(r, d, "rand");
    end

    // Slow sine: each level is held 500 clocks and plateaus at v * 246.
    for (int n = 0; n < 20; n++) begin
      s = 2048.0 * $sin(3.14159265358979 * n / 10.0);
      v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
      repeat (500) tick(1'b0, 32'(v), "sine");
      chk("sine_plateau", data_out, v * 246);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
Name: fir_filter

Overview:
- Fixed-coefficient, direct-form, 16-tap FIR low-pass filter for the beamformer datapath.
- Accepts one signed 32-bit sample every clock and produces one full-precision signed 96-bit result every clock.
- Sits between the sample source (ADC/stimulus) and downstream beam summation/decimation logic.

Parameters:
- NUM_TAPS, 16, number of taps; must match the coefficient table length in the package.
- DIN_W, 32, input sample width, signed two's complement.
- COEF_W, 32, coefficient width, signed two's complement.
- DOUT_W, 96, output width, signed, full precision with no rounding or saturation.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high; clears all state on a rising clk edge while high.
- data_in  input  32  signed input sample; sampled on every rising clk edge, no valid qualifier.
- data_out  output  96  signed filtered result, registered.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst=1 at a rising edge, the following clear to 0: delay line x[0..15], product registers p[0..15], data_out. Reset has priority over sample capture.
- Delay line: each edge (rst=0), x[0]<=data_in and x[i]<=x[i-1] for i=1..15.
- Multiply stage: each edge, p[i]<=x[i]*COEFFS[i] as a signed 32x32 multiply giving a 64-bit product.
- Sum stage: each edge, data_out<=sign_extend_96(sum of p[0..15]).
  - Accumulate at no less than 68 bits.
  - No overflow is possible at these widths.
- Latency: a sample present on data_in at edge k contributes COEFFS[0]*sample to data_out after edge k+2.
  - General form: data_out(k+2) = sum over i of COEFFS[i]*data_in(k-i).
- Throughput: one result per clock; the pipeline never stalls.
- Coefficients: constant, symmetric, linear phase.
  - COEFFS[0..15] = 1,3,7,12,18,24,28,30,30,28,24,18,12,7,3,1.
  - DC gain = 246.
- Reset mid-stream: the entire history is discarded.
  - After rst is released, data_out is 0 until new samples propagate.
  - The output is computed as if all prior samples were 0.
- Extremes: data_in=-2^31 held constant gives data_out=-528280977408 in steady state, correctly sign-extended.

Decomposition:
- Package fir_filter_pkg holds:
  - localparams NUM_TAPS, DIN_W, COEF_W, PROD_W=64, DOUT_W.
  - The COEFFS constant array.
  - A typedef for the signed sample, product and accumulator types.
- One natural sub-module: fir_adder_tree.
  - Combinational sum of NUM_TAPS signed 64-bit products into a signed 96-bit result.
  - Instantiated between the product registers and the data_out register.

Test Plan:
- Reset: hold rst=1 for 5 cycles with data_in=12345 -> data_out=0 throughout; data_out still 0 on the first edge after release.
- Impulse: after reset, drive data_in=1 for one cycle (edge k), then 0 -> data_out after edges k+2..k+17 = 1,3,7,12,18,24,28,30,30,28,24,18,12,7,3,1, then 0.
- Step: hold data_in=2048 -> data_out ramps through partial sums and settles at 503808 from edge k+17 onward.
- Negative full scale: hold data_in=-2^31 -> steady data_out=-528280977408 with upper bits all 1.
- Reset mid-operation: during the 2048 step, assert rst for one cycle -> data_out=0 on the next edge, then the step response restarts from 2048 at latency 2.
- Sine stream: drive round(2048*sin(pi*n/10)), new n every 500 clocks -> data_out matches a bit-exact golden convolution model on every cycle, with a plateau of 2048*246*sin value between transitions.
